// File: rtl/shared_adder_scheduler.sv
// Round-robin shared 4-bit CLA slice: two requesters, wide adds evaluated nibble-serially.
// Define SHARED_ADDER_OVF_EN to compile in two's-complement overflow; otherwise rsp_ovf is tied to 0.
module shared_adder_scheduler #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 rsp_id,
    output logic                 busy
);
    localparam int W  = 4 * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic            prio, grant, accept, last;
    logic [W-1:0]    a_reg, b_reg, sum_reg;
    logic            carry, cout_reg, id_reg;
    logic [CW-1:0]   cnt;
    logic [3:0]      nib_a, nib_b, nib_sum;
    logic            nib_cout;

    function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic c0);
        logic [3:0] p, g;
        logic [4:0] c;
        p    = a ^ b;
        g    = a & b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    // Contention goes to prio; a lone requester always wins.
    assign grant      = (req0_valid && req1_valid) ? prio : req1_valid;
    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign nib_a = a_reg[int'(cnt)*4 +: 4];
    assign nib_b = b_reg[int'(cnt)*4 +: 4];
    assign {nib_cout, nib_sum} = cla4(nib_a, nib_b, carry);
    assign last  = (cnt == CW'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = CALC;
            CALC:    if (last)      state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operands are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= grant ? req1_a : req0_a;
            b_reg <= grant ? req1_b : req0_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            cnt      <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            id_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    carry  <= grant ? req1_cin : req0_cin;
                    cnt    <= '0;
                    id_reg <= grant;
                    prio   <= ~grant;
                end
                CALC: begin
                    sum_reg[int'(cnt)*4 +: 4] <= nib_sum;
                    carry <= nib_cout;
                    cnt   <= cnt + 1'b1;
                    if (last) cout_reg <= nib_cout;
                end
                default: ;
            endcase
        end
    end

`ifdef SHARED_ADDER_OVF_EN
    logic ovf_reg;
    // Carry into the MSB is recovered from the sum bit: s3 = a3 ^ b3 ^ c3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    ovf_reg <= 1'b0;
        else if (state == CALC && last) ovf_reg <= (nib_sum[3] ^ nib_a[3] ^ nib_b[3]) ^ nib_cout;
    end
    assign rsp_ovf = ovf_reg;
`else
    assign rsp_ovf = 1'b0;
`endif

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_sum   = sum_reg;
    assign rsp_cout  = cout_reg;
    assign rsp_id    = id_reg;
endmodule
